key_para_ctrl: RTL and testbench

- Input-side counterpart of the LED control path. Scans 4 active-low push-buttons and debounces them.
- Turns button presses into an 8-bit control byte, para_out, which drives the LED controller's led_para input.
- All timing runs from a single clk, using tick enables. No derived or ripple clocks.
- Supports increment/decrement with long-press auto-repeat, a wrap/saturate mode toggle, and a clear key.

---
 rtl/key_pkg.sv | 31 +++
 rtl/key_para_ctrl_if.sv | 11 +
 rtl/key_debounce.sv | 64 ++++++
 rtl/key_para_ctrl.sv | 128 ++++++++++++
 tb/tb_key_para_ctrl.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared key indices, repeat-FSM and action encodings for key_para_ctrl
package key_pkg;

   localparam int KEY_INC  = 0;
   localparam int KEY_DEC  = 1;
   localparam int KEY_MODE = 2;
   localparam int KEY_CLR  = 3;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      REPEAT
   } rpt_state_e;

   typedef enum logic [2:0] {
      NONE,
      CLR,
      MODE,
      INC,
      DEC
   } action_e;

   // One inc/dec step; saturates at the rails unless wrap is set.
   function automatic logic [7:0] para_step(input logic [7:0] v, input logic up, input logic wrap);
      if (up) begin
         return (wrap || v != 8'hFF) ? v + 8'd1 : v;
      end
      return (wrap || v != 8'h00) ? v - 8'd1 : v;
   endfunction

endpackage

// File: rtl/key_para_ctrl_if.sv
// rtl/key_para_ctrl_if.sv - button inputs and control-byte outputs of key_para_ctrl
interface key_para_ctrl_if;
   logic [3:0] key_n;
   logic [7:0] para_out;
   logic       para_valid;
   logic       wrap_mode;
   logic [3:0] key_state;

   modport master (output key_n, input para_out, para_valid, wrap_mode, key_state);
   modport slave  (input key_n, output para_out, para_valid, wrap_mode, key_state);
endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key synchroniser, tick-based debounce and press-event pulse
module key_debounce #(
   parameter int DEB_TICKS = 20
) (
   input  logic clk,
   input  logic reset_n,
   input  logic tick,
   input  logic key_n_i,
   output logic key_state_o,
   output logic press_o
);
   localparam int CW = $clog2(DEB_TICKS + 1);

   logic          sync1_q, sync1_d, sync2_q, sync2_d;
   logic [1:0]    vld_q, vld_d;
   logic          armed_q, armed_d;
   logic          state_q, state_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d = ~key_n_i;
      sync2_d = sync1_q;
      vld_d   = {vld_q[0], 1'b1};
      // A key held through reset must be seen released before it can fire again.
      armed_d = armed_q | (vld_q[1] & ~sync2_q);
      state_d = state_q;
      cnt_d   = cnt_q;
      if (sync2_q == state_q) begin
         cnt_d = '0;
      end else if (tick) begin
         if (cnt_q == CW'(DEB_TICKS - 1)) begin
            state_d = ~state_q;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      press_d = state_d & ~state_q & armed_q;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         vld_q   <= '0;
         armed_q <= 1'b0;
         state_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         vld_q   <= vld_d;
         armed_q <= armed_d;
         state_q <= state_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign key_state_o = state_q;
   assign press_o     = press_q;
endmodule

// File: rtl/key_para_ctrl.sv
// rtl/key_para_ctrl.sv - debounced 4-key front end producing the LED control byte
module key_para_ctrl
   import key_pkg::*;
#(
   parameter int         CLK_HZ     = 50_000_000,
   parameter int         TICK_HZ    = 1000,
   parameter int         DEB_TICKS  = 20,
   parameter int         HOLD_TICKS = 500,
   parameter int         REP_TICKS  = 100,
   parameter logic [7:0] PARA_INIT  = 8'd0
) (
   input  logic            clk,
   input  logic            reset_n,
   key_para_ctrl_if.slave  kif
);
   localparam int DIV  = CLK_HZ / TICK_HZ;
   localparam int TW   = $clog2(DIV);
   localparam int RMAX = (HOLD_TICKS > REP_TICKS) ? HOLD_TICKS : REP_TICKS;
   localparam int RW   = $clog2(RMAX + 1);

   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic          tick;
   logic [3:0]    key_state, press;
   rpt_state_e    rpt_state_q [2];
   rpt_state_e    rpt_state_d [2];
   logic [RW-1:0] rpt_cnt_q [2];
   logic [RW-1:0] rpt_cnt_d [2];
   logic [1:0]    rep_ev;
   action_e       act;
   logic [7:0]    para_q, para_d;
   logic          wrap_q, wrap_d, valid_q, valid_d;

   assign tick = (tick_cnt_q == TW'(DIV - 1));

   for (genvar g = 0; g < 4; g++) begin : g_key
      key_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
         .clk         (clk),
         .reset_n     (reset_n),
         .tick        (tick),
         .key_n_i     (kif.key_n[g]),
         .key_state_o (key_state[g]),
         .press_o     (press[g])
      );
   end

   always_comb begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
      for (int i = 0; i < 2; i++) begin
         rpt_state_d[i] = rpt_state_q[i];
         rpt_cnt_d[i]   = rpt_cnt_q[i];
         rep_ev[i]      = 1'b0;
         if (!key_state[i]) begin
            rpt_state_d[i] = IDLE;
            rpt_cnt_d[i]   = '0;
         end else begin
            case (rpt_state_q[i])
               IDLE: if (press[i]) begin
                  rpt_state_d[i] = HOLD;
                  rpt_cnt_d[i]   = '0;
               end
               HOLD: if (tick) begin
                  if (rpt_cnt_q[i] == RW'(HOLD_TICKS - 1)) begin
                     rpt_state_d[i] = REPEAT;
                     rpt_cnt_d[i]   = '0;
                     rep_ev[i]      = 1'b1;
                  end else begin
                     rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
                  end
               end
               REPEAT: if (tick) begin
                  if (rpt_cnt_q[i] == RW'(REP_TICKS - 1)) begin
                     rpt_cnt_d[i] = '0;
                     rep_ev[i]    = 1'b1;
                  end else begin
                     rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
                  end
               end
               default: rpt_state_d[i] = IDLE;
            endcase
         end
      end

      // Single action per cycle; losers are dropped, not queued.
      act = NONE;
      if (press[KEY_CLR])                          act = CLR;
      else if (press[KEY_MODE])                    act = MODE;
      else if (press[KEY_INC] || rep_ev[KEY_INC])  act = INC;
      else if (press[KEY_DEC] || rep_ev[KEY_DEC])  act = DEC;

      para_d  = para_q;
      wrap_d  = wrap_q;
      valid_d = (act != NONE);
      case (act)
         CLR:     para_d = PARA_INIT;
         MODE:    wrap_d = ~wrap_q;
         INC:     para_d = para_step(para_q, 1'b1, wrap_q);
         DEC:     para_d = para_step(para_q, 1'b0, wrap_q);
         default: para_d = para_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tick_cnt_q <= '0;
         for (int i = 0; i < 2; i++) begin
            rpt_state_q[i] <= IDLE;
            rpt_cnt_q[i]   <= '0;
         end
         para_q  <= PARA_INIT;
         wrap_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         for (int i = 0; i < 2; i++) begin
            rpt_state_q[i] <= rpt_state_d[i];
            rpt_cnt_q[i]   <= rpt_cnt_d[i];
         end
         para_q  <= para_d;
         wrap_q  <= wrap_d;
         valid_q <= valid_d;
      end
   end

   assign kif.para_out   = para_q;
   assign kif.para_valid = valid_q;
   assign kif.wrap_mode  = wrap_q;
   assign kif.key_state  = key_state;
endmodule

// File: tb/tb_key_para_ctrl.sv
// tb/tb_key_para_ctrl.sv - self-checking bench for key_para_ctrl
module tb_key_para_ctrl;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   vcount = 0;
   int   pulse_q[$];
   int   rise_cyc = -1;
   int   fall_cyc = -1;
   logic ks0_prev = 1'b0;

   key_para_ctrl_if kif();

   key_para_ctrl #(
      .CLK_HZ     (1000),
      .TICK_HZ    (100),
      .DEB_TICKS  (3),
      .HOLD_TICKS (5),
      .REP_TICKS  (2),
      .PARA_INIT  (8'h10)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .kif     (kif)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (kif.para_valid === 1'b1) begin
         vcount = vcount + 1;
         pulse_q.push_back(cyc);
      end
      if (kif.key_state[0] && !ks0_prev) rise_cyc = cyc;
      if (!kif.key_state[0] && ks0_prev) fall_cyc = cyc;
      ks0_prev = kif.key_state[0];
   end

   typedef struct {
      logic [3:0] key_n;
      int         hold;
      int         exp_para;
      int         exp_wrap;
      int         exp_pulses;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic press_keys(input logic [3:0] pat, input int hold);
      @(negedge clk);
      kif.key_n = pat;
      repeat (hold) @(negedge clk);
      kif.key_n = 4'hF;
   endtask

   function automatic int pulse_at(input int idx);
      if (idx < pulse_q.size()) return pulse_q[idx];
      return -1;
   endfunction

   initial begin
      int v0, q0, start, r;
      int n;
      vecs[0] = '{4'b1110, 15,  'h10, 0, 0};
      vecs[1] = '{4'b1110, 40,  'h11, 0, 1};
      vecs[2] = '{4'b0111, 40,  'h10, 0, 1};
      vecs[3] = '{4'b1101, 40,  'h0F, 0, 1};
      vecs[4] = '{4'b1101, 500, 'h00, 0, 24};
      vecs[5] = '{4'b1101, 40,  'h00, 0, 1};
      vecs[6] = '{4'b1011, 40,  'h00, 1, 1};
      vecs[7] = '{4'b1101, 40,  'hFF, 1, 1};
      vecs[8] = '{4'b0011, 40,  'h10, 1, 1};

      kif.key_n = 4'hF;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // idle after reset
      v0 = vcount;
      repeat (200) @(negedge clk);
      chk("idle_para", int'(kif.para_out), 'h10);
      chk("idle_wrap", int'(kif.wrap_mode), 0);
      chk("idle_key_state", int'(kif.key_state), 0);
      chk("idle_pulses", vcount - v0, 0);

      for (int i = 0; i < 9; i++) begin
         v0 = vcount;
         press_keys(vecs[i].key_n, vecs[i].hold);
         repeat (80) @(negedge clk);
         chk($sformatf("row%0d_para", i), int'(kif.para_out), vecs[i].exp_para);
         chk($sformatf("row%0d_wrap", i), int'(kif.wrap_mode), vecs[i].exp_wrap);
         chk($sformatf("row%0d_pulses", i), vcount - v0, vecs[i].exp_pulses);
         chk($sformatf("row%0d_key_state", i), int'(kif.key_state), 0);
      end

      // long press: first step, hold delay, auto-repeat cadence, stop on release
      v0 = vcount;
      q0 = pulse_q.size();
      start = cyc;
      press_keys(4'b1110, 160);
      repeat (80) @(negedge clk);
      r = rise_cyc;
      chk("rpt_rise_seen", int'(r > start), 1);
      chk("rpt_hold_len", fall_cyc - r, 160);
      chk("rpt_pulses", vcount - v0, 7);
      chk("rpt_first", pulse_at(q0) - r, 1);
      chk("rpt_second", pulse_at(q0 + 1) - r, 50);
      chk("rpt_third", pulse_at(q0 + 2) - r, 70);
      chk("rpt_last", pulse_at(q0 + 6) - r, 150);
      chk("rpt_para", int'(kif.para_out), 'h17);

      // reset during auto-repeat
      @(negedge clk);
      kif.key_n = 4'b1110;
      n = 0;
      while (kif.para_out !== 8'h20 && n < 800) begin
         @(negedge clk);
         n++;
      end
      chk("rst_reach_0x20", int'(kif.para_out), 'h20);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      v0 = vcount;
      chk("rst_para", int'(kif.para_out), 'h10);
      chk("rst_wrap", int'(kif.wrap_mode), 0);
      chk("rst_key_state", int'(kif.key_state), 0);
      repeat (200) @(negedge clk);
      chk("rst_held_pulses", vcount - v0, 0);
      chk("rst_held_para", int'(kif.para_out), 'h10);
      kif.key_n = 4'hF;
      repeat (80) @(negedge clk);
      v0 = vcount;
      press_keys(4'b1110, 40);
      repeat (80) @(negedge clk);
      chk("rst_repress_pulses", vcount - v0, 1);
      chk("rst_repress_para", int'(kif.para_out), 'h11);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
